spi_ram_responder: RTL and testbench
====================================

Name: spi_ram_responder

Overview:
- Synthesizable SPI SRAM responder (23LC-style): the target end of the instruction-fetch SPI link driven by the CPU's program-memory initiator.
- Uses SPI mode 0, with a READ (0x03) / WRITE (0x02) command set, a 16-bit address and sequential auto-increment.
- Oversamples the SPI pins on the system clock; backed by an internal byte array.
- Used as the on-die program store in simulation/FPGA benches. A backdoor port preloads programs.

Parameters:
- ADDR_W, 8, stored address bits; DEPTH = 2**ADDR_W bytes; upper address bits ignored.
- SYNC_STAGES, 2, flop stages on spi_cs/spi_sck/spi_mosi before edge detection (min 2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- spi_cs  in  1  chip select, active low
- spi_sck  in  1  SPI clock, idle low (mode 0)
- spi_mosi  in  1  serial data from initiator, MSB first
- spi_miso  out  1  serial data to initiator, MSB first
- spi_miso_oe  out  1  MISO output enable (1 only during a read data phase)
- busy  out  1  1 while synchronized CS is low
- ld_en  in  1  backdoor byte write strobe
- ld_addr  in  ADDR_W  backdoor address
- ld_data  in  8  backdoor write data
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  8  registered memory[dbg_addr], 1-cycle latency

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high. Reset does not clear the memory array.
- Reset values: spi_miso=0, spi_miso_oe=0, busy=0, dbg_data=0, state=IDLE, bit counter=0, shift registers=0, address=0.
- Synchronisation: spi_cs, spi_sck and spi_mosi each pass through SYNC_STAGES flops.
  - Rise/fall pulses come from the last stage vs. a delayed copy.
  - Supported timing: SCK high and low phases each ≥ SYNC_STAGES+3 clk; CS low to first SCK rise ≥ SYNC_STAGES+3 clk.
- Mode 0: MOSI sampled on synchronized SCK rise; MISO updated on synchronized SCK fall.
- States: IDLE, CMD, ADDR, RD, WR, IGNORE.
  - IDLE: on CS fall go to CMD; clear bit counter.
  - CMD: shift 8 bits. Next state:
    - 0x03 → ADDR (read)
    - 0x02 → ADDR (write)
    - any other value → IGNORE
  - ADDR: shift 16 bits; address register = low ADDR_W bits.
    - Read: on the 16th address rise, fetch memory[addr] into the TX shifter.
    - Read: on the following SCK fall, assert spi_miso_oe and drive bit7; go to RD.
    - Write: go to WR.
  - RD: each SCK fall shifts out the next bit.
    - After bit0 has been sampled (8th rise of the byte), addr increments and memory[addr] is fetched.
    - The next fall drives bit7 of the new byte.
  - WR: each SCK rise shifts MOSI in. On the 8th rise of a byte, memory[addr] ← byte and addr increments.
  - IGNORE: miso_oe=0, no memory access, until CS rises.
- Address wrap: increment is modulo DEPTH (DEPTH-1 → 0), in both RD and WR.
- CS rise in any state: next clk go to IDLE; miso_oe=0, spi_miso=0. A partial write byte (<8 bits) is discarded. No increment for incomplete bytes.
- busy = synchronized CS low.
- Backdoor:
  - ld_en writes memory[ld_addr] ← ld_data on the clock edge, only when busy=0.
  - ld_en while busy=1 is ignored.
  - The backdoor never collides with SPI writes.
- dbg_data = memory[dbg_addr] registered every cycle. It reflects a write in the same cycle on the next cycle (read-after-write returns new data one cycle later).
- SCK edges while CS is high are ignored.
- rst asserted mid-transaction: returns to IDLE and drops miso_oe. No write is performed for an in-flight byte.

Optional Feature:
- Macro: SPI_RAM_RDSR_EN.
- Defined: adds an 8-bit mode register, reset 0x40 (sequential), and two commands.
  - RDSR 0x05: after the command byte, the mode register is shifted out on MISO (oe=1), repeating until CS rises.
  - WRSR 0x01: the next 8 bits are written to the mode register on the 8th rise; further bits are ignored.
  - Mode[7:6]=00 (byte mode): after one data byte, RD/WR go to IGNORE.
  - Mode[7:6]=01 or 1x: sequential, as above.
- Undefined: no mode register; 0x05/0x01 behave as unknown commands (IGNORE); always sequential.

Test Plan:
- SPI WRITE 0x02, addr 0x0010, data 0xA5; CS high; READ 0x03 addr 0x0010, 8 clocks → MISO bits 1010_0101; dbg_addr=0x10 gives dbg_data=0xA5.
- Backdoor ld 0x11,0x22,0x33,0x44 at 0x20..0x23; READ 0x0020 for 32 SCK → MISO stream 0x11223344; miso_oe=1 only during the data phase.
- ADDR_W=8: WRITE at 0x00FF data 0xDE,0xAD → mem[0xFF]=0xDE, mem[0x00]=0xAD; READ 0x01FF → 0xDE then 0xAD (upper bits ignored, wrap).
- WRITE 0x0005 data 0x77 with CS raised after 5 data bits → mem[5] unchanged; next READ 0x0005 returns the old value.
- Command 0x9F + 24 clocks → miso_oe stays 0, no memory change; a following READ works normally.
- rst pulsed during RD data → miso_oe=0 next cycle; state IDLE; with ld_en during busy=1 → no write to memory.

Source files
------------

// File: rtl/spi_ram_responder.sv
// spi_ram_responder: SPI mode-0 SRAM target (READ 0x03 / WRITE 0x02, 16-bit address, auto-increment) with backdoor load and debug read.
// Latency: pins cross SYNC_STAGES flops plus an edge-detect stage, and MISO changes one clk after a detected SCK fall; dbg_data lags dbg_addr by 1 clk.
// Backpressure: none, because the initiator paces every transfer with SCK. Defining SPI_RAM_RDSR_EN adds the RDSR/WRSR mode register.
module spi_ram_responder #(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              busy,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD,
        ST_WR,
        ST_IGNORE
`ifdef SPI_RAM_RDSR_EN
        ,
        ST_RDSR,
        ST_WRSR
`endif
    } state_t;

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_d;
    logic                   r_sck_d;

    logic w_cs;
    logic w_sck;
    logic w_mosi;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_busy;

    state_t            r_state;
    logic [4:0]        r_bit_cnt;
    logic [6:0]        r_cmd_sh;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_tx_sh;
    logic              r_is_write;
    logic              r_miso;
    logic              r_miso_oe;
    logic [7:0]        r_dbg_data;
    logic [7:0]        r_mem [DEPTH];

    state_t            w_state_nxt;
    logic [4:0]        w_bit_cnt_nxt;
    logic [6:0]        w_cmd_sh_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        w_tx_sh_nxt;
    logic              w_is_write_nxt;
    logic              w_miso_nxt;
    logic              w_miso_oe_nxt;
    logic              w_spi_we;

    logic [7:0]        w_byte;
    logic [ADDR_W-1:0] w_addr_shift;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic [7:0]        w_fetch_data;
    logic              w_seq;

`ifdef SPI_RAM_RDSR_EN
    logic [7:0] r_mode;
    logic [7:0] w_mode_nxt;
    assign w_seq = (r_mode[7:6] != 2'b00);
`else
    assign w_seq = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_sync   <= '1;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_d      <= 1'b1;
            r_sck_d     <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_cs_d      <= w_cs;
            r_sck_d     <= w_sck;
        end
    end

    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_fall  = r_cs_d & ~w_cs;
    assign w_cs_rise  = ~r_cs_d & w_cs;
    // SCK activity is only meaningful while the part is selected.
    assign w_sck_rise = w_sck & ~r_sck_d & ~w_cs;
    assign w_sck_fall = ~w_sck & r_sck_d & ~w_cs;
    assign w_busy     = ~w_cs;

    assign w_byte       = {r_cmd_sh, w_mosi};
    assign w_addr_shift = {r_addr[ADDR_W-2:0], w_mosi};
    assign w_addr_inc   = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_fetch_addr = (r_state == ST_ADDR) ? w_addr_shift : w_addr_inc;
    assign w_fetch_data = r_mem[w_fetch_addr];

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_cmd_sh_nxt   = r_cmd_sh;
        w_addr_nxt     = r_addr;
        w_tx_sh_nxt    = r_tx_sh;
        w_is_write_nxt = r_is_write;
        w_miso_nxt     = r_miso;
        w_miso_oe_nxt  = r_miso_oe;
        w_spi_we       = 1'b0;
`ifdef SPI_RAM_RDSR_EN
        w_mode_nxt     = r_mode;
`endif
        if (w_cs_rise) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = 5'd0;
            w_miso_nxt    = 1'b0;
            w_miso_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        w_state_nxt   = ST_CMD;
                        w_bit_cnt_nxt = 5'd0;
                    end
                end
                ST_CMD: begin
                    if (w_sck_rise) begin
                        w_cmd_sh_nxt  = w_byte[6:0];
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd7) begin
                            w_bit_cnt_nxt = 5'd0;
                            case (w_byte)
                                8'h03: begin
                                    w_state_nxt    = ST_ADDR;
                                    w_is_write_nxt = 1'b0;
                                end
                                8'h02: begin
                                    w_state_nxt    = ST_ADDR;
                                    w_is_write_nxt = 1'b1;
                                end
`ifdef SPI_RAM_RDSR_EN
                                8'h05: begin
                                    w_state_nxt = ST_RDSR;
                                    w_tx_sh_nxt = r_mode;
                                end
                                8'h01: w_state_nxt = ST_WRSR;
`endif
                                default: w_state_nxt = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    // Count 16 marks a completed read address waiting for the first data fall.
                    if (r_bit_cnt == 5'd16) begin
                        if (w_sck_fall) begin
                            w_miso_oe_nxt = 1'b1;
                            w_miso_nxt    = r_tx_sh[7];
                            w_tx_sh_nxt   = {r_tx_sh[6:0], 1'b0};
                            w_bit_cnt_nxt = 5'd0;
                            w_state_nxt   = ST_RD;
                        end
                    end else if (w_sck_rise) begin
                        w_addr_nxt    = w_addr_shift;
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd15) begin
                            if (r_is_write) begin
                                w_state_nxt   = ST_WR;
                                w_bit_cnt_nxt = 5'd0;
                            end else begin
                                w_tx_sh_nxt = w_fetch_data;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (w_sck_fall) begin
                        w_miso_nxt  = r_tx_sh[7];
                        w_tx_sh_nxt = {r_tx_sh[6:0], 1'b0};
                    end else if (w_sck_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd7) begin
                            w_bit_cnt_nxt = 5'd0;
                            w_addr_nxt    = w_addr_inc;
                            w_tx_sh_nxt   = w_fetch_data;
                            if (!w_seq) begin
                                w_state_nxt   = ST_IGNORE;
                                w_miso_oe_nxt = 1'b0;
                                w_miso_nxt    = 1'b0;
                            end
                        end
                    end
                end
                ST_WR: begin
                    if (w_sck_rise) begin
                        w_cmd_sh_nxt  = w_byte[6:0];
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd7) begin
                            w_spi_we      = 1'b1;
                            w_bit_cnt_nxt = 5'd0;
                            w_addr_nxt    = w_addr_inc;
                            if (!w_seq) begin
                                w_state_nxt = ST_IGNORE;
                            end
                        end
                    end
                end
`ifdef SPI_RAM_RDSR_EN
                ST_RDSR: begin
                    // Rotating rather than shifting repeats the mode byte until deselect.
                    if (w_sck_fall) begin
                        w_miso_oe_nxt = 1'b1;
                        w_miso_nxt    = r_tx_sh[7];
                        w_tx_sh_nxt   = {r_tx_sh[6:0], r_tx_sh[7]};
                    end
                end
                ST_WRSR: begin
                    if (w_sck_rise) begin
                        w_cmd_sh_nxt  = w_byte[6:0];
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd7) begin
                            w_mode_nxt    = w_byte;
                            w_bit_cnt_nxt = 5'd0;
                            w_state_nxt   = ST_IGNORE;
                        end
                    end
                end
`endif
                ST_IGNORE: begin
                    w_miso_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_miso_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 5'd0;
            r_cmd_sh   <= '0;
            r_addr     <= '0;
            r_tx_sh    <= '0;
            r_is_write <= 1'b0;
            r_miso     <= 1'b0;
            r_miso_oe  <= 1'b0;
`ifdef SPI_RAM_RDSR_EN
            r_mode     <= 8'h40;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_cmd_sh   <= w_cmd_sh_nxt;
            r_addr     <= w_addr_nxt;
            r_tx_sh    <= w_tx_sh_nxt;
            r_is_write <= w_is_write_nxt;
            r_miso     <= w_miso_nxt;
            r_miso_oe  <= w_miso_oe_nxt;
`ifdef SPI_RAM_RDSR_EN
            r_mode     <= w_mode_nxt;
`endif
        end
    end

    // The array is deliberately left out of reset; the backdoor only loads while deselected.
    always_ff @(posedge clk) begin
        if (w_spi_we && !rst) begin
            r_mem[r_addr] <= w_byte;
        end else if (ld_en && !w_busy) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= r_mem[dbg_addr];
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_miso_oe;
    assign busy        = w_busy;
    assign dbg_data    = r_dbg_data;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Bench for spi_ram_responder: random SPI traffic checked against a byte-array model of the SRAM.
module tb_spi_ram_responder;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam int HALF   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              spi_cs;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              busy;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic [ADDR_W-1:0] dbg_addr;
    logic [7:0]        dbg_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_mem [DEPTH];
    logic [7:0] wr_buf [8];
    logic [7:0] rd_buf [8];
    int         rd_oe_low;
    logic       oe_allowed = 1'b0;
    int         oe_violations = 0;

    always #5 clk = ~clk;

    spi_ram_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_cs      (spi_cs),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .busy        (busy),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // MISO may only be enabled inside a window the bench opened for a data phase.
    always @(negedge clk) begin
        if (spi_miso_oe && !oe_allowed) oe_violations++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_start();
        spi_sck = 1'b0;
        spi_cs  = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic spi_stop();
        wait_clk(HALF);
        spi_cs = 1'b1;
        wait_clk(12);
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx, output int oe_low);
        rx     = 8'h00;
        oe_low = 0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            wait_clk(HALF);
            rx = {rx[6:0], spi_miso};
            if (!spi_miso_oe) oe_low++;
            spi_sck = 1'b1;
            wait_clk(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_write(input logic [15:0] addr, input int n);
        logic [7:0] rx;
        int         ol;
        spi_start();
        spi_byte(8'h02, 8, rx, ol);
        spi_byte(addr[15:8], 8, rx, ol);
        spi_byte(addr[7:0], 8, rx, ol);
        for (int i = 0; i < n; i++) spi_byte(wr_buf[i], 8, rx, ol);
        spi_stop();
    endtask

    task automatic spi_read(input logic [15:0] addr, input int n);
        logic [7:0] rx;
        int         ol;
        rd_oe_low = 0;
        spi_start();
        spi_byte(8'h03, 8, rx, ol);
        spi_byte(addr[15:8], 8, rx, ol);
        spi_byte(addr[7:0], 8, rx, ol);
        oe_allowed = 1'b1;
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, 8, rd_buf[i], ol);
            rd_oe_low += ol;
        end
        spi_stop();
        oe_allowed = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        wait_clk(3);
        checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
        checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b want 0", spi_miso_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (dbg_data !== 8'h00) begin failures++; $display("FAIL reset_dbg: got %h want 00", dbg_data); end
        rst = 1'b0;
        wait_clk(4);
    endtask

    task automatic preload();
        for (int a = 0; a < DEPTH; a++) begin
            ld_en = 1'b1; ld_addr = 8'(a); ld_data = 8'($urandom);
            model_mem[a] = ld_data;
            wait_clk(1);
        end
        ld_en = 1'b0;
        wait_clk(2);
    endtask

    task automatic test_dbg();
        logic [7:0] a;
        logic [7:0] old_v;
        logic [7:0] new_v;
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom); dbg_addr = a;
            wait_clk(1);
            checks++; if (dbg_data !== model_mem[a]) begin failures++; $display("FAIL dbg_read[%0h]: got %h want %h", a, dbg_data, model_mem[a]); end
        end
        a = 8'($urandom); old_v = model_mem[a]; new_v = ~old_v;
        dbg_addr = a; ld_en = 1'b1; ld_addr = a; ld_data = new_v;
        wait_clk(1);
        ld_en = 1'b0; model_mem[a] = new_v;
        checks++; if (dbg_data !== old_v) begin failures++; $display("FAIL dbg_raw_same: got %h want %h", dbg_data, old_v); end
        wait_clk(1);
        checks++; if (dbg_data !== new_v) begin failures++; $display("FAIL dbg_raw_next: got %h want %h", dbg_data, new_v); end
    endtask

    task automatic test_write_read();
        wr_buf[0] = 8'hA5;
        spi_write(16'h0010, 1);
        model_mem[8'h10] = 8'hA5;
        spi_read(16'h0010, 1);
        checks++; if (rd_buf[0] !== 8'hA5) begin failures++; $display("FAIL wr_rd_miso: got %h want a5", rd_buf[0]); end
        dbg_addr = 8'h10;
        wait_clk(1);
        checks++; if (dbg_data !== 8'hA5) begin failures++; $display("FAIL wr_rd_dbg: got %h want a5", dbg_data); end
    endtask

    task automatic test_backdoor_stream();
        logic [7:0] pat [4];
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            ld_en = 1'b1; ld_addr = 8'(8'h20 + i); ld_data = pat[i];
            model_mem[8'h20 + i] = pat[i];
            wait_clk(1);
        end
        ld_en = 1'b0;
        spi_read(16'h0020, 4);
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_buf[i] !== pat[i]) begin failures++; $display("FAIL stream_byte%0d: got %h want %h", i, rd_buf[i], pat[i]); end
        end
        checks++; if (rd_oe_low !== 0) begin failures++; $display("FAIL stream_oe_data: oe low at %0d data samples, want 0", rd_oe_low); end
        checks++; if (oe_violations !== 0) begin failures++; $display("FAIL stream_oe_window: %0d cycles outside data phase, want 0", oe_violations); end
    endtask

    task automatic test_wrap();
        wr_buf[0] = 8'hDE; wr_buf[1] = 8'hAD;
        spi_write(16'h00FF, 2);
        model_mem[8'hFF] = 8'hDE; model_mem[8'h00] = 8'hAD;
        spi_read(16'h01FF, 2);
        checks++; if (rd_buf[0] !== 8'hDE) begin failures++; $display("FAIL wrap_rd0: got %h want de", rd_buf[0]); end
        checks++; if (rd_buf[1] !== 8'hAD) begin failures++; $display("FAIL wrap_rd1: got %h want ad", rd_buf[1]); end
        dbg_addr = 8'h00;
        wait_clk(1);
        checks++; if (dbg_data !== 8'hAD) begin failures++; $display("FAIL wrap_mem0: got %h want ad", dbg_data); end
    endtask

    task automatic test_partial_write();
        logic [7:0] rx;
        int         ol;
        logic [7:0] old_v;
        old_v = model_mem[5];
        spi_start();
        spi_byte(8'h02, 8, rx, ol);
        spi_byte(8'h00, 8, rx, ol);
        spi_byte(8'h05, 8, rx, ol);
        spi_byte(8'h77, 5, rx, ol);
        spi_stop();
        spi_read(16'h0005, 1);
        checks++; if (rd_buf[0] !== old_v) begin failures++; $display("FAIL partial_write: got %h want %h", rd_buf[0], old_v); end
    endtask

    task automatic test_unknown_cmd();
        logic [7:0] rx;
        int         ol;
        int         bad;
        int         base_viol;
        base_viol = oe_violations;
        spi_start();
        spi_byte(8'h9F, 8, rx, ol);
        for (int i = 0; i < 3; i++) spi_byte(8'($urandom), 8, rx, ol);
        spi_stop();
        checks++; if (oe_violations !== base_viol) begin failures++; $display("FAIL unknown_oe: %0d oe cycles, want 0", oe_violations - base_viol); end
        bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            dbg_addr = 8'(a);
            wait_clk(1);
            if (dbg_data !== model_mem[a]) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL unknown_mem: %0d bytes differ, want 0", bad); end
        spi_read(16'h0010, 1);
        checks++; if (rd_buf[0] !== model_mem[8'h10]) begin failures++; $display("FAIL unknown_then_read: got %h want %h", rd_buf[0], model_mem[8'h10]); end
    endtask

    task automatic test_random();
        logic [15:0] wa;
        logic [15:0] ra;
        int          n;
        int          m;
        logic [7:0]  exp_v;
        for (int it = 0; it < 8; it++) begin
            wa = 16'($urandom);
            n  = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                wr_buf[i] = 8'($urandom);
                model_mem[8'(wa[7:0] + i)] = wr_buf[i];
            end
            spi_write(wa, n);
            ra = (it % 2 == 0) ? wa : 16'($urandom);
            m  = $urandom_range(1, 5);
            spi_read(ra, m);
            for (int i = 0; i < m; i++) begin
                exp_v = model_mem[8'(ra[7:0] + i)];
                checks++; if (rd_buf[i] !== exp_v) begin failures++; $display("FAIL random_rd it%0d byte%0d: got %h want %h", it, i, rd_buf[i], exp_v); end
            end
            checks++; if (rd_oe_low !== 0) begin failures++; $display("FAIL random_oe it%0d: oe low at %0d data samples", it, rd_oe_low); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        int         ol;
        int         t;
        spi_start();
        spi_byte(8'h03, 8, rx, ol);
        spi_byte(8'h00, 8, rx, ol);
        spi_byte(8'h30, 8, rx, ol);
        oe_allowed = 1'b1;
        spi_byte(8'h00, 8, rx, ol);
        spi_byte(8'h00, 3, rx, ol);
        wait_clk(3);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        checks++; if (spi_miso_oe !== 1'b0) begin failures++; $display("FAIL rstmid_oe: got %b want 0", spi_miso_oe); end
        checks++; if (spi_miso !== 1'b0) begin failures++; $display("FAIL rstmid_miso: got %b want 0", spi_miso); end
        oe_allowed = 1'b0;
        t = 0;
        while (busy !== 1'b1 && t < 20) begin wait_clk(1); t++; end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy: got %b want 1 within 20 clk", busy); end
        ld_en = 1'b1; ld_addr = 8'h40; ld_data = ~model_mem[8'h40];
        wait_clk(1);
        ld_en = 1'b0;
        spi_cs = 1'b1;
        wait_clk(12);
        dbg_addr = 8'h40;
        wait_clk(1);
        checks++; if (dbg_data !== model_mem[8'h40]) begin failures++; $display("FAIL rstmid_ld_busy: got %h want %h", dbg_data, model_mem[8'h40]); end
        spi_read(16'h0030, 2);
        checks++; if (rd_buf[1] !== model_mem[8'h31]) begin failures++; $display("FAIL rstmid_after_read: got %h want %h", rd_buf[1], model_mem[8'h31]); end
        checks++; if (oe_violations !== 0) begin failures++; $display("FAIL rstmid_oe_window: %0d stray oe cycles", oe_violations); end
    endtask

    task automatic test_status_cmd();
        logic [7:0] rx;
        int         ol;
`ifdef SPI_RAM_RDSR_EN
        spi_start();
        spi_byte(8'h05, 8, rx, ol);
        oe_allowed = 1'b1;
        spi_byte(8'h00, 8, rx, ol);
        checks++; if (rx !== 8'h40) begin failures++; $display("FAIL rdsr_first: got %h want 40", rx); end
        spi_byte(8'h00, 8, rx, ol);
        checks++; if (rx !== 8'h40) begin failures++; $display("FAIL rdsr_repeat: got %h want 40", rx); end
        spi_stop();
        oe_allowed = 1'b0;
`else
        int base_viol;
        base_viol = oe_violations;
        spi_start();
        spi_byte(8'h05, 8, rx, ol);
        spi_byte(8'h00, 8, rx, ol);
        spi_stop();
        checks++; if (oe_violations !== base_viol) begin failures++; $display("FAIL rdsr_absent_oe: %0d oe cycles, want 0", oe_violations - base_viol); end
`endif
    endtask

    initial begin
        test_reset();
        preload();
        test_dbg();
        test_write_read();
        test_backdoor_stream();
        test_wrap();
        test_partial_write();
        test_unknown_cmd();
        test_random();
        test_reset_mid();
        test_status_cmd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
